// File: rtl/fetch_pc_unit_pkg.sv
// Shared fetch-stage constants: bubble instruction, reset vector and fetch state encoding.
package fetch_pc_unit_pkg;

  localparam int          XLEN_DEF         = 32;
  localparam logic [31:0] NOP_INST_DEF     = 32'h0000_0013;
  localparam logic [31:0] RESET_VECTOR_DEF = 32'h0000_0000;

  localparam logic [1:0] FS_BOOT   = 2'd0;
  localparam logic [1:0] FS_RUN    = 2'd1;
  localparam logic [1:0] FS_SQUASH = 2'd2;

  function automatic logic addr_misaligned(input logic [31:0] addr);
    return |addr[1:0];
  endfunction

endpackage

// File: rtl/fetch_next_pc_mux.sv
// Next-PC priority mux: redirect over hold over jump-generator result; purely combinational.
module fetch_next_pc_mux
  import fetch_pc_unit_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic            redirect_i,
  input  logic            hold_i,
  input  logic [XLEN-1:0] ex_target_i,
  input  logic [XLEN-1:0] jump_addr_i,
  input  logic [XLEN-1:0] pc_q_i,
  output logic [XLEN-1:0] imem_addr_o,
  output logic [XLEN-1:0] pc_d_o
);

  always_comb begin
    if (redirect_i) begin
      imem_addr_o = ex_target_i;
    end else if (hold_i) begin
      imem_addr_o = pc_q_i;
    end else begin
      imem_addr_o = jump_addr_i;
    end
  end

  // pc_q always tracks the address just issued, so the next cycle's rdata belongs to it
  assign pc_d_o = imem_addr_o;

endmodule

// File: rtl/fetch_pc_unit.sv
// Instruction-fetch PC owner for the IF stage; drives the 1-cycle synchronous imem and squashes wrong-path fetches.
// Optional misaligned-fetch trap (flag + PC freeze until redirect) under FETCH_MISALIGN_TRAP_EN.
module fetch_pc_unit
  import fetch_pc_unit_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEF,
  parameter logic [31:0] NOP_INST     = NOP_INST_DEF,
  parameter int          XLEN         = XLEN_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            ex_redirect,
  input  logic [XLEN-1:0] ex_target,
  input  logic [XLEN-1:0] jump_addr,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] if_pc,
  output logic [XLEN-1:0] if_inst,
  output logic            if_valid
`ifdef FETCH_MISALIGN_TRAP_EN
  ,
  output logic            fetch_misalign
`endif
);

  logic [1:0]      state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            in_boot;
  logic            redirect_eff;
  logic            hold;
  logic            trap_block;

  assign in_boot      = (state_q == FS_BOOT);
  assign redirect_eff = ex_redirect & ~in_boot;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic misalign_q, misalign_d;

  assign trap_block     = misalign_q;
  assign fetch_misalign = misalign_q;

  // A redirect re-arms the flag from its own target; otherwise it is sticky
  always_comb begin
    misalign_d = misalign_q;
    if (redirect_eff) begin
      misalign_d = addr_misaligned(ex_target);
    end else if (!in_boot) begin
      misalign_d = misalign_q | addr_misaligned(pc_d);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= misalign_d;
    end
  end
`else
  assign trap_block = 1'b0;
`endif

  // Memory data is not yet valid in BOOT, so the PC is held there
  assign hold = in_boot | stall | trap_block;

  fetch_next_pc_mux #(
    .XLEN (XLEN)
  ) u_next_pc_mux (
    .redirect_i  (redirect_eff),
    .hold_i      (hold),
    .ex_target_i (ex_target),
    .jump_addr_i (jump_addr),
    .pc_q_i      (pc_q),
    .imem_addr_o (imem_addr),
    .pc_d_o      (pc_d)
  );

  always_comb begin
    state_d = FS_RUN;
    if (redirect_eff) begin
      state_d = FS_SQUASH;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FS_BOOT;
      pc_q    <= RESET_VECTOR;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  assign if_valid = ~in_boot & ~ex_redirect & ~trap_block;
  assign if_inst  = if_valid ? imem_rdata : NOP_INST;
  assign if_pc    = pc_q;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Randomized + directed bench for fetch_pc_unit against a next-address reference model and a synchronous memory model.
module tb_fetch_pc_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] RV  = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        ex_redirect = 1'b0;
  logic [31:0] ex_target = '0;
  logic [31:0] jump_addr = '0;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        if_valid;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic        fetch_misalign;
`endif

  int total = 0;
  int bad   = 0;

  // Reference model: address whose data is on rdata, boot flag, trap flag
  logic        m_boot = 1'b1;
  logic [31:0] m_pc   = RV;
  logic        m_mis  = 1'b0;

  fetch_pc_unit dut (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall),
    .ex_redirect(ex_redirect),
    .ex_target  (ex_target),
    .jump_addr  (jump_addr),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .if_pc      (if_pc),
    .if_inst    (if_inst),
    .if_valid   (if_valid)
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    .fetch_misalign(fetch_misalign)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B1) + 32'h0000_0101;
  endfunction

  always @(posedge clk) imem_rdata <= memf(imem_addr);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Called just after a negedge: drive, check, update model, advance one cycle
  task automatic cyc(input logic st, input logic rd, input logic [31:0] tgt, input logic [31:0] jmp);
    logic        ev;
    logic [31:0] ea;
    logic [31:0] ei;
    stall = st; ex_redirect = rd; ex_target = tgt; jump_addr = jmp;
    #1;
    if (m_boot) begin
      ev = 1'b0; ea = m_pc;
    end else if (rd) begin
      ev = 1'b0; ea = tgt;
    end else if (st || m_mis) begin
      ev = !m_mis; ea = m_pc;
    end else begin
      ev = 1'b1; ea = jmp;
    end
    ei = ev ? memf(m_pc) : NOP;
    chk("valid", {31'b0, if_valid}, {31'b0, ev});
    chk("addr",  imem_addr, ea);
    chk("inst",  if_inst, ei);
    chk("pc",    if_pc, m_pc);
`ifdef FETCH_MISALIGN_TRAP_EN
    chk("misalign", {31'b0, fetch_misalign}, {31'b0, m_mis});
    if (!m_boot) m_mis = rd ? (tgt[1:0] != 2'b00) : (m_mis || ea[1:0] != 2'b00);
`endif
    m_pc   = ea;
    m_boot = 1'b0;
    @(negedge clk);
  endtask

  task automatic seq(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 32'h0, m_pc + 32'd4);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    stall = 1'b1; ex_redirect = 1'b1; ex_target = 32'h0000_0AA0; jump_addr = 32'h0000_0BB0;
    #1;
    chk("rst_valid", {31'b0, if_valid}, 32'h0);
    chk("rst_inst",  if_inst, NOP);
    chk("rst_pc",    if_pc, RV);
    chk("rst_addr",  imem_addr, RV);
`ifdef FETCH_MISALIGN_TRAP_EN
    chk("rst_misalign", {31'b0, fetch_misalign}, 32'h0);
`endif
    @(negedge clk);
    #1;
    chk("rst_addr2", imem_addr, RV);
    @(negedge clk);
    rst = 1'b0;
    m_boot = 1'b1; m_pc = RV; m_mis = 1'b0;
  endtask

  task automatic rand_cycles(input int n);
    logic        st, rd;
    logic [31:0] tgt, jmp;
    for (int i = 0; i < n; i++) begin
      rd  = ($urandom_range(7) == 0);
      st  = ($urandom_range(3) == 0);
      tgt = $urandom & 32'hFFFF_FFFC;
      jmp = ($urandom_range(3) == 0) ? ($urandom & 32'hFFFF_FFFC) : (m_pc + 32'd4);
      cyc(st, rd, tgt, jmp);
    end
  endtask

  initial begin
    @(negedge clk);
    do_reset();
    // BOOT ignores stall and redirect
    cyc(1'b1, 1'b1, 32'h0000_0500, 32'h0000_0999);
    seq(3);
    // Redirect at 0x20 to 0x40
    cyc(1'b0, 1'b1, 32'h0000_0020, 32'h0);
    cyc(1'b0, 1'b1, 32'h0000_0040, m_pc + 32'd4);
    seq(2);
    // Stall three cycles at 0x10
    cyc(1'b0, 1'b1, 32'h0000_000C, 32'h0);
    seq(1);
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 32'h0, m_pc + 32'd4);
    seq(2);
    // JAL from 0x100 to 0x180
    cyc(1'b0, 1'b1, 32'h0000_0100, 32'h0);
    cyc(1'b0, 1'b0, 32'h0, 32'h0000_0180);
    seq(1);
    // Stall and redirect together
    cyc(1'b1, 1'b1, 32'h0000_0200, m_pc + 32'd4);
    seq(2);
    // Wrap past the top of the address space
    cyc(1'b0, 1'b1, 32'hFFFF_FFF8, 32'h0);
    seq(4);
    // Misaligned jump target, then redirect to 0x300
    cyc(1'b0, 1'b0, 32'h0, 32'h0000_0102);
    seq(3);
    cyc(1'b0, 1'b1, 32'h0000_0300, m_pc + 32'd4);
    seq(2);
    rand_cycles(400);
    // Reset asserted in the middle of a stall
    cyc(1'b1, 1'b0, 32'h0, m_pc + 32'd4);
    do_reset();
    seq(3);
    rand_cycles(200);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_pc_unit.md
Name: fetch_pc_unit

Overview:
- Instruction-fetch stage of the three-stage pipeline (IF → ID/EX → WB).
- Owns the program counter and drives the synchronous instruction memory address.
- Presents the fetched instruction and its PC to the jump-target generator and the decode/execute stage.
- Selects the next PC from: execute-stage redirect (branch/JALR), stall hold, or the jump-generator result (JAL target or PC+4). Squashes wrong-path instructions.

Parameters:
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset.
- NOP_INST, 32'h0000_0013, instruction emitted on bubbles (addi x0,x0,0).
- XLEN, 32, address/data width; only 32 is supported.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- stall  in  1  hold request from downstream hazard logic.
- ex_redirect  in  1  taken branch or JALR resolved in execute.
- ex_target  in  32  redirect target address.
- jump_addr  in  32  jump-generator output for if_inst/if_pc (JAL target or PC+4).
- imem_addr  out  32  instruction memory read address (combinational).
- imem_rdata  in  32  instruction memory data, one cycle after imem_addr.
- if_pc  out  32  PC of the instruction on if_inst.
- if_inst  out  32  fetched instruction, or NOP_INST when not valid.
- if_valid  out  1  if_inst is a real, non-squashed instruction.

Behaviour:
- Reset (async, any time, including mid-stall or mid-redirect):
  - pc_q = RESET_VECTOR; state = BOOT.
  - Outputs during reset: if_valid=0, if_inst=NOP_INST, if_pc=RESET_VECTOR, imem_addr=RESET_VECTOR.
- Invariant: pc_q is the address whose data is on imem_rdata this cycle. Memory read latency is exactly 1 cycle.
- States:
  - BOOT: first cycle after reset release. Memory output is not yet valid, so if_valid=0 and imem_addr=RESET_VECTOR.
    - Next cycle → RUN; pc_q unchanged.
    - Redirect and stall are ignored in BOOT.
  - RUN: if_valid=1 unless squashed. if_inst=imem_rdata; if_pc=pc_q.
  - SQUASH: entered on the cycle after a redirect. Data belongs to ex_target and is valid (if_valid=1); behaves exactly as RUN. Kept as a distinct encoding for debug and coverage only.
- Next-PC priority (RUN/SQUASH), highest first:
  1. ex_redirect=1 → imem_addr=ex_target; pc_q<=ex_target.
     - This cycle: if_valid forced 0 and if_inst=NOP_INST (wrong-path squash).
     - Next state → SQUASH.
  2. stall=1 → imem_addr=pc_q; pc_q holds. if_inst/if_pc/if_valid unchanged (same address re-read).
  3. Otherwise → imem_addr=jump_addr; pc_q<=jump_addr.
- When if_valid=0, the downstream jump generator sees NOP_INST and supplies pc_q+4. The block does not add 4 itself.
- Address arithmetic wraps modulo 2^32; 32'hFFFF_FFFC + 4 → 0. Bits [1:0] of targets are passed through unmodified.
- Simultaneous stall and ex_redirect: redirect wins; stall is dropped for that cycle.
- Back-to-back redirects: each one applies, latest target wins.
- No combinational path from imem_rdata to imem_addr except via the external jump_addr loop.
  - Implementer must keep that loop acyclic: jump_addr depends on if_inst; imem_addr depends on jump_addr.

Optional Feature:
- Macro: FETCH_MISALIGN_TRAP_EN.
- With the macro defined:
  - Add output fetch_misalign (1 bit), registered.
  - It is set the cycle after any next-PC with bit[1]|bit[0] != 0, and cleared by reset or by the next redirect.
  - While fetch_misalign=1: if_valid is forced 0 and pc_q freezes until ex_redirect arrives.
- Without the macro: no extra port. Misaligned targets are fetched as-is, with no flag and no freeze.

Decomposition:
- Shared package/header (alongside the existing opcode definitions):
  - NOP_INST constant.
  - Fetch state encoding FS_BOOT, FS_RUN, FS_SQUASH (2 bits).
  - RESET_VECTOR default.
- One natural sub-module: fetch_next_pc_mux. Purely combinational priority mux producing imem_addr and the pc_q D-input from ex_redirect, stall, jump_addr, ex_target, pc_q.
- The top holds pc_q, the state register and output gating.

Test Plan:
- Reset/boot: assert rst mid-run, release.
  - BOOT cycle: if_valid=0, imem_addr=0x0.
  - Next cycle: if_valid=1, if_pc=0x0; then if_pc 0x4, 0x8 with jump_addr=pc+4.
- JAL: if_pc=0x100, jump_addr=0x180 → imem_addr=0x180 same cycle; next cycle if_pc=0x180, if_valid=1.
- Redirect: ex_redirect=1, ex_target=0x40 at if_pc=0x20.
  - That cycle: if_valid=0, if_inst=0x00000013.
  - Next cycle: if_pc=0x40, if_valid=1, state SQUASH.
- Stall 3 cycles at if_pc=0x10: imem_addr=0x10 throughout; if_pc/if_inst stable; resume gives 0x14.
- Stall and redirect together (stall=1, ex_redirect=1, ex_target=0x200) → redirect taken; next if_pc=0x200.
- With FETCH_MISALIGN_TRAP_EN: jump_addr=0x102 → fetch_misalign=1 next cycle, if_valid=0, pc frozen; redirect to 0x300 clears it.
